// File: rtl/act_readout_engine_pkg.sv
// Shared widths, field positions, FSM encoding and helpers for the activation read-back engine.
package act_readout_engine_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned RDATA_W = 32;
    localparam int unsigned CNT_W   = 12;
    localparam int unsigned IDX_W   = 12;
    localparam int unsigned VAL_W   = 16;
    localparam int unsigned PE_W    = 6;
    localparam int unsigned SLOT_W  = 6;
    localparam int unsigned PE_LSB  = 10;
    localparam int unsigned ACT_LSB = 0;
    localparam int unsigned IDX_LSB = 16;
    localparam int unsigned VAL_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_IRQ = 2'd1,
        ST_ISSUE    = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [VAL_W-1:0] act;
    } act_beat_t;

    // PE index in the upper field, activation slot in the lower field, gap bits zero.
    function automatic logic [ADDR_W-1:0] make_addr(input logic [PE_W-1:0]   pe,
                                                     input logic [SLOT_W-1:0] slot);
        logic [ADDR_W-1:0] a;
        a = '0;
        a[PE_LSB +: PE_W]    = pe;
        a[ACT_LSB +: SLOT_W] = slot;
        return a;
    endfunction

    // Extract the {index, value} pair carried by a read response word.
    function automatic act_beat_t unpack_rdata(input logic [RDATA_W-1:0] w);
        act_beat_t b;
        b.idx = w[IDX_LSB +: IDX_W];
        b.act = w[VAL_LSB +: VAL_W];
        return b;
    endfunction

endpackage

// File: rtl/act_readout_engine_sync_fifo.sv
// Synchronous FIFO with occupancy count; push on a full FIFO is accepted when a pop happens the same cycle.
module act_readout_engine_sync_fifo #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Qualify push/pop against occupancy.
    always_comb begin
        rd_ok = pop && !empty;
        wr_ok = push && (!full || rd_ok);
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
        end
    end

endmodule

// File: rtl/act_readout_engine.sv
// Activation read-back sequencer: waits for the accelerator interrupt, walks
// addresses PE-first with credit-limited reads, buffers responses and streams them out.
module act_readout_engine
    import act_readout_engine_pkg::*;
#(
    parameter int unsigned NUM_PE     = 64,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   act_no,
    input  logic               interrupt,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               read_en,
    input  logic               read_rdy,
    output logic [ADDR_W-1:0]  read_addr,
    output logic               read_data_rdy,
    input  logic               read_data_vld,
    input  logic [RDATA_W-1:0] read_data,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [IDX_W-1:0]   out_idx,
    output logic [VAL_W-1:0]   out_act
);

    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OCC_W  = FCNT_W + 2;
    localparam int unsigned BEAT_W = $bits(act_beat_t);

    state_t            state;
    state_t            state_next;

    logic [CNT_W-1:0]  act_no_q;
    logic [CNT_W-1:0]  req_cnt;
    logic [CNT_W-1:0]  rsp_cnt;
    logic [FCNT_W-1:0] outstanding;
    logic [PE_W-1:0]   pe_idx;
    logic [SLOT_W-1:0] act_addr;
    logic              armed;

    logic              fifo_full;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_count;
    act_beat_t         fifo_head;
    act_beat_t         rsp_beat;

    logic              start_ok;
    logic              xfer;
    logic              push;
    logic              pop;
    logic              rsp_err;
    logic              rsp_ok;

    logic              busy_next;
    logic              done_next;
    logic              read_en_next;
    logic [CNT_W-1:0]  req_cnt_next;
    logic [CNT_W-1:0]  rsp_cnt_next;
    logic [FCNT_W-1:0] outstanding_next;
    logic [PE_W-1:0]   pe_idx_next;
    logic [SLOT_W-1:0] act_addr_next;
    logic [FCNT_W-1:0] fifo_count_next;
    logic              out_vld_next;
    logic [OCC_W-1:0]  occ_next;

    assign read_data_rdy = !fifo_full;
    assign rsp_beat      = unpack_rdata(read_data);
    assign start_ok      = start && (state == ST_IDLE);

    // Handshake qualifiers; responses are dropped until the first start after reset.
    always_comb begin
        xfer    = read_en && read_rdy;
        push    = read_data_vld && !fifo_full && armed;
        rsp_err = push && (outstanding == '0);
        rsp_ok  = push && (outstanding != '0);
        pop     = !fifo_empty && (!out_vld || out_rdy);
    end

    // Next values of counters, address walker and buffer occupancy (output stage counts as one slot).
    always_comb begin
        req_cnt_next     = req_cnt;
        rsp_cnt_next     = rsp_cnt;
        outstanding_next = outstanding;
        pe_idx_next      = pe_idx;
        act_addr_next    = act_addr;
        if (start_ok) begin
            req_cnt_next     = '0;
            rsp_cnt_next     = '0;
            outstanding_next = '0;
            pe_idx_next      = '0;
            act_addr_next    = '0;
        end else begin
            if (xfer) begin
                req_cnt_next = req_cnt + CNT_W'(1);
                if (pe_idx == PE_W'(NUM_PE - 1)) begin
                    pe_idx_next   = '0;
                    act_addr_next = act_addr + SLOT_W'(1);
                end else begin
                    pe_idx_next = pe_idx + PE_W'(1);
                end
            end
            rsp_cnt_next     = rsp_cnt + CNT_W'(push);
            outstanding_next = outstanding + FCNT_W'(xfer) - FCNT_W'(rsp_ok);
        end
        fifo_count_next = fifo_count + FCNT_W'(push) - FCNT_W'(pop);
        out_vld_next    = pop ? 1'b1 : (out_rdy ? 1'b0 : out_vld);
        occ_next        = OCC_W'(outstanding_next) + OCC_W'(fifo_count_next) + OCC_W'(out_vld_next);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and next values of the registered control outputs.
    always_comb begin
        state_next   = state;
        busy_next    = busy;
        done_next    = 1'b0;
        read_en_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    if (act_no == '0) begin
                        done_next = 1'b1;
                    end else begin
                        busy_next  = 1'b1;
                        state_next = ST_WAIT_IRQ;
                    end
                end
            end
            ST_WAIT_IRQ: begin
                if (interrupt) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (read_en && !read_rdy) begin
                    read_en_next = 1'b1;
                end else begin
                    read_en_next = (req_cnt_next < act_no_q) && (occ_next < OCC_W'(FIFO_DEPTH));
                end
                if (req_cnt_next == act_no_q) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((rsp_cnt == act_no_q) && fifo_empty && (!out_vld || out_rdy)) begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Control outputs, counters and request address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            read_en     <= 1'b0;
            read_addr   <= '0;
            act_no_q    <= '0;
            req_cnt     <= '0;
            rsp_cnt     <= '0;
            outstanding <= '0;
            pe_idx      <= '0;
            act_addr    <= '0;
            armed       <= 1'b0;
        end else begin
            busy        <= busy_next;
            done        <= done_next;
            err         <= start_ok ? 1'b0 : (err || rsp_err);
            read_en     <= read_en_next;
            read_addr   <= make_addr(pe_idx_next, act_addr_next);
            req_cnt     <= req_cnt_next;
            rsp_cnt     <= rsp_cnt_next;
            outstanding <= outstanding_next;
            pe_idx      <= pe_idx_next;
            act_addr    <= act_addr_next;
            if (start_ok) begin
                act_no_q <= act_no;
                armed    <= 1'b1;
            end
        end
    end

    // Output stage: head of FIFO is loaded when the stage is empty or being consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_idx <= '0;
            out_act <= '0;
        end else begin
            out_vld <= out_vld_next;
            if (pop) begin
                out_idx <= fifo_head.idx;
                out_act <= fifo_head.act;
            end
        end
    end

    act_readout_engine_sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (rsp_beat),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_act_readout_engine.sv
// Directed bench for act_readout_engine with a one-cycle-latency accelerator responder.
module tb_act_readout_engine;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] act_no;
    logic        interrupt;
    logic        busy;
    logic        done;
    logic        err;
    logic        read_en;
    logic        read_rdy;
    logic [15:0] read_addr;
    logic        read_data_rdy;
    logic        read_data_vld;
    logic [31:0] read_data;
    logic        out_vld;
    logic        out_rdy;
    logic [11:0] out_idx;
    logic [15:0] out_act;

    int n_checks = 0;
    int n_errs   = 0;
    int done_cnt = 0;
    int spur_cnt = 0;
    int spur_done = 0;

    logic [15:0] got_addr [$];
    logic [27:0] got_beat [$];
    logic [31:0] pend [$];

    act_readout_engine #(
        .NUM_PE     (64),
        .FIFO_DEPTH (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .act_no        (act_no),
        .interrupt     (interrupt),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .read_en       (read_en),
        .read_rdy      (read_rdy),
        .read_addr     (read_addr),
        .read_data_rdy (read_data_rdy),
        .read_data_vld (read_data_vld),
        .read_data     (read_data),
        .out_vld       (out_vld),
        .out_rdy       (out_rdy),
        .out_idx       (out_idx),
        .out_act       (out_act)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected address of the k-th request (0-based): PE = k mod 64, slot = k div 64.
    function automatic logic [15:0] exp_addr(input int k);
        return 16'(((k % 64) * 1024) + (k / 64));
    endfunction

    // Accelerator reply: index = slot*64 + PE, value = address scrambled.
    function automatic logic [31:0] rsp_word(input logic [15:0] a);
        return {4'h0, a[5:0], a[15:10], a ^ 16'hA5A5};
    endfunction

    task automatic do_start(input logic [11:0] n);
        act_no = n;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int c;
        c = 0;
        while (done !== 1'b1 && c < max_cyc) begin
            tick();
            c++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic check_run(input string tag, input int ba, input int bb, input int n);
        check({tag, "_nreq"}, 32'(got_addr.size() - ba), 32'(n));
        check({tag, "_nbeat"}, 32'(got_beat.size() - bb), 32'(n));
        for (int k = 0; k < n; k++) begin
            if (ba + k < got_addr.size()) begin
                check($sformatf("%s_addr%0d", tag, k), 32'(got_addr[ba + k]), 32'(exp_addr(k)));
            end
            if (bb + k < got_beat.size()) begin
                check($sformatf("%s_beat%0d", tag, k), 32'(got_beat[bb + k]),
                      32'({12'(k), exp_addr(k) ^ 16'hA5A5}));
            end
        end
    endtask

    // Accelerator model and observation: sample mid-cycle, drive just after the rising edge.
    initial begin
        logic acc;
        read_data_vld = 1'b0;
        read_data     = '0;
        forever begin
            @(negedge clk);
            acc = read_data_vld && read_data_rdy;
            if (read_en && read_rdy) begin
                got_addr.push_back(read_addr);
                pend.push_back(rsp_word(read_addr));
            end
            if (out_vld && out_rdy) begin
                got_beat.push_back({out_idx, out_act});
            end
            if (done) begin
                done_cnt++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                read_data_vld = 1'b0;
            end
            if (!read_data_vld) begin
                if (spur_cnt != spur_done) begin
                    spur_done++;
                    read_data_vld = 1'b1;
                    read_data     = 32'h0ABC_1234;
                end else if (pend.size() > 0) begin
                    read_data_vld = 1'b1;
                    read_data     = pend.pop_front();
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   ba;
        int   bb;
        int   bd;
        logic seen;

        rst_n     = 1'b0;
        start     = 1'b0;
        act_no    = '0;
        interrupt = 1'b0;
        read_rdy  = 1'b1;
        out_rdy   = 1'b1;
        repeat (3) tick();

        // Reset values
        check("rst_read_en", 32'(read_en), 32'd0);
        check("rst_read_addr", 32'(read_addr), 32'd0);
        check("rst_read_data_rdy", 32'(read_data_rdy), 32'd1);
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_act", 32'(out_act), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic run of 5 activations
        ba = got_addr.size(); bb = got_beat.size(); bd = done_cnt;
        do_start(12'd5);
        check("t1_busy_rise", 32'(busy), 32'd1);
        interrupt = 1'b1;
        wait_done("t1", 200);
        tick();
        check("t1_done_count", 32'(done_cnt - bd), 32'd1);
        check("t1_a0", 32'(got_addr[ba]), 32'h0000);
        check("t1_a4", 32'(got_addr[ba + 4]), 32'h1000);
        check_run("t1", ba, bb, 5);
        check("t1_err", 32'(err), 32'd0);

        // PE wrap into the next activation slot
        ba = got_addr.size(); bb = got_beat.size();
        do_start(12'd66);
        wait_done("t2", 600);
        check("t2_req64", 32'(got_addr[ba + 63]), 32'hFC00);
        check("t2_req65", 32'(got_addr[ba + 64]), 32'h0001);
        check("t2_req66", 32'(got_addr[ba + 65]), 32'h0401);
        check_run("t2", ba, bb, 66);

        // Back-pressure: credits cap outstanding + buffered at FIFO_DEPTH
        out_rdy = 1'b0;
        ba = got_addr.size(); bb = got_beat.size();
        do_start(12'd20);
        repeat (20) tick();
        check("t3_hold_idx_a", 32'(out_idx), 32'd0);
        check("t3_hold_act_a", 32'(out_act), 32'hA5A5);
        repeat (20) tick();
        check("t3_nreq_capped", 32'(got_addr.size() - ba), 32'd8);
        check("t3_read_en_low", 32'(read_en), 32'd0);
        check("t3_out_vld", 32'(out_vld), 32'd1);
        check("t3_hold_idx_b", 32'(out_idx), 32'd0);
        check("t3_hold_act_b", 32'(out_act), 32'hA5A5);
        check("t3_busy", 32'(busy), 32'd1);
        out_rdy = 1'b1;
        wait_done("t3", 600);
        check_run("t3", ba, bb, 20);

        // Interrupt gating, second start ignored, read_en/addr held under stall
        interrupt = 1'b0;
        read_rdy  = 1'b0;
        ba = got_addr.size(); bb = got_beat.size();
        do_start(12'd3);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) begin
                act_no = 12'd7;
                start  = 1'b1;
            end else begin
                start  = 1'b0;
            end
            tick();
            seen = seen | read_en;
        end
        start = 1'b0;
        check("t4_no_req_wo_irq", 32'(seen), 32'd0);
        interrupt = 1'b1;
        tick();
        check("t4_read_en_irq_plus1", 32'(read_en), 32'd0);
        tick();
        check("t4_read_en_irq_plus2", 32'(read_en), 32'd1);
        repeat (3) tick();
        check("t4_read_en_held", 32'(read_en), 32'd1);
        check("t4_addr_held", 32'(read_addr), 32'h0000);
        read_rdy = 1'b1;
        wait_done("t4", 200);
        check_run("t4", ba, bb, 3);

        // Zero-length request and spurious response
        ba = got_addr.size();
        do_start(12'd0);
        check("t5_done_zero", 32'(done), 32'd1);
        check("t5_busy_zero", 32'(busy), 32'd0);
        tick();
        check("t5_done_zero_pulse", 32'(done), 32'd0);
        repeat (3) tick();
        check("t5_no_reads", 32'(got_addr.size() - ba), 32'd0);
        spur_cnt++;
        repeat (5) tick();
        check("t5_err_set", 32'(err), 32'd1);
        check("t5_spur_beat", 32'(got_beat[got_beat.size() - 1]), 32'h0ABC1234);
        ba = got_addr.size(); bb = got_beat.size();
        do_start(12'd2);
        check("t5_err_cleared", 32'(err), 32'd0);
        wait_done("t5", 200);
        check_run("t5", ba, bb, 2);

        // Asynchronous reset in the middle of ISSUE
        do_start(12'd30);
        repeat (5) tick();
        check("t6_issuing", 32'(read_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_read_en", 32'(read_en), 32'd0);
        check("t6_rst_read_addr", 32'(read_addr), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_out_vld", 32'(out_vld), 32'd0);
        check("t6_rst_out_idx", 32'(out_idx), 32'd0);
        check("t6_rst_out_act", 32'(out_act), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_rst_err", 32'(err), 32'd0);
        bb = got_beat.size();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("t6_dropped_no_beat", 32'(got_beat.size() - bb), 32'd0);
        check("t6_dropped_no_err", 32'(err), 32'd0);
        check("t6_idle_out_vld", 32'(out_vld), 32'd0);
        ba = got_addr.size(); bb = got_beat.size();
        do_start(12'd4);
        check("t6_busy_rise", 32'(busy), 32'd1);
        wait_done("t6", 200);
        check_run("t6", ba, bb, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
